// File: rtl/pc_gen.sv
// Program counter generator for the fetch stage.
// Selects the next fetch address from trap entry, trap return, branch
// redirects (immediate or deferred across a stall) and sequential flow.
// All state advances on the falling clock edge to line up with core fetch.
module pc_gen #(
  parameter int                XLEN       = 32,
  parameter logic [XLEN-1:0]   RESET_ADDR = '0,
  parameter logic [31:0]       TRAP_VEC   = 32'h0000_0100,
  parameter int                STEP       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redir_en,
  input  logic [XLEN-1:0] redir_addr,
  input  logic            trap_en,
  input  logic            mret_en,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic [XLEN-1:0] epc,
  output logic            misalign
);

  localparam logic [XLEN-1:0] TRAP_PC = XLEN'(TRAP_VEC);
  localparam logic [XLEN-1:0] STEP_W  = XLEN'(STEP);

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    RUN       = 2'd1,
    HOLD      = 2'd2,
    HOLD_PEND = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            pc_valid_q, pc_valid_d;
  logic            misalign_q, misalign_d;
  logic            redir_misaligned;

  assign redir_misaligned = redir_en && (redir_addr[1:0] != 2'b00);

  // Next-state selection, highest-priority event first.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    pend_d     = pend_q;
    misalign_d = 1'b0;

    if (trap_en) begin
      // Trap entry wins everywhere, including the boot cycle.
      pc_d    = TRAP_PC;
      epc_d   = pc_q;
      pend_d  = '0;
      state_d = RUN;
    end else if (state_q == BOOT) begin
      // Boot edge: keep the reset address, ignore everything but trap.
      state_d = RUN;
    end else if (mret_en) begin
      pc_d    = epc_q;
      pend_d  = '0;
      state_d = RUN;
    end else if (redir_misaligned) begin
      // A bad redirect target enters the trap handler instead.
      pc_d       = TRAP_PC;
      epc_d      = pc_q;
      pend_d     = '0;
      misalign_d = 1'b1;
      state_d    = RUN;
    end else if (redir_en) begin
      if (stall) begin
        // Park the target until the stall lifts; newer redirects overwrite.
        pend_d  = redir_addr;
        state_d = HOLD_PEND;
      end else begin
        // A live redirect supersedes any parked one.
        pc_d    = redir_addr;
        pend_d  = '0;
        state_d = RUN;
      end
    end else if (state_q == HOLD_PEND) begin
      if (!stall) begin
        pc_d    = pend_q;
        pend_d  = '0;
        state_d = RUN;
      end
    end else if (stall) begin
      state_d = HOLD;
    end else begin
      // Sequential fetch; wraps silently at the top of the address space.
      pc_d    = pc_q + STEP_W;
      state_d = RUN;
    end

    // The boot edge still presents the reset address as not-yet-valid.
    pc_valid_d = (state_d == RUN) && !((state_q == BOOT) && !trap_en);
  end

  // State and output registers, asynchronously cleared by reset.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_ADDR;
      epc_q      <= '0;
      pend_q     <= '0;
      pc_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      pend_q     <= pend_d;
      pc_valid_q <= pc_valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign epc      = epc_q;
  assign misalign = misalign_q;

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32: width of all address ports and registers.
REQ-002 Parameter RESET_ADDR, default 0: PC value loaded by reset.
REQ-003 Parameter TRAP_VEC, default 32'h0000_0100: trap entry address, truncated to XLEN.
REQ-004 Parameter STEP, default 4: sequential increment.
REQ-005 clk  input  1  core clock; all state SHALL update on the falling edge, matching core fetch timing.
REQ-006 rst  input  1  asynchronous, active-low reset; asserted when 0.
REQ-007 stall  input  1  hold request from the pipeline.
REQ-008 redir_en  input  1  branch/jump redirect strobe.
REQ-009 redir_addr  input  XLEN  redirect target.
REQ-010 trap_en  input  1  exception/interrupt entry strobe.
REQ-011 mret_en  input  1  return-from-trap strobe.
REQ-012 pc  output  XLEN  current fetch address.
REQ-013 pc_valid  output  1  pc is a valid fetch address this cycle.
REQ-014 epc  output  XLEN  saved exception PC.
REQ-015 misalign  output  1  one-cycle pulse when a redirect target is rejected as misaligned.

Function
REQ-016 FSM states SHALL be BOOT, RUN, HOLD and HOLD_PEND, held in a registered state variable.
REQ-017 Per-edge priority SHALL be trap_en > mret_en > misaligned redirect > redir_en > pending redirect > stall > sequential.
REQ-018 Trap: pc<=TRAP_VEC, epc<=pc, pending cleared, state<=RUN, regardless of stall or current state (BOOT included).
REQ-019 Mret (trap_en=0): pc<=epc, pending cleared, state<=RUN, regardless of stall.
REQ-020 Misaligned redirect (redir_en=1 and redir_addr[1:0]!=0): treat as a trap, with pc<=TRAP_VEC, epc<=pc and misalign=1 for exactly that cycle; pending SHALL NOT be loaded.
REQ-021 Aligned redirect, stall=0, state RUN or HOLD: pc<=redir_addr, state<=RUN.
REQ-022 Aligned redirect, stall=1: pc SHALL hold, pend_addr<=redir_addr, state<=HOLD_PEND; a later redirect while in HOLD_PEND SHALL overwrite pend_addr.
REQ-023 HOLD_PEND with stall=0 and no higher-priority event: pc<=pend_addr, state<=RUN; with stall=0 and an aligned redir_en, redir_addr SHALL win over pend_addr.
REQ-024 RUN or HOLD with stall=1 and no redirect: pc SHALL hold, state<=HOLD.
REQ-025 RUN or HOLD with stall=0 and no event: pc<=pc+STEP modulo 2^XLEN (wrap-around with no flag), state<=RUN.
REQ-026 BOOT: pc SHALL hold RESET_ADDR for one edge after reset release, then state<=RUN; only trap_en SHALL be honoured in BOOT, and all other inputs SHALL be ignored.
REQ-027 pc_valid SHALL be registered: 1 in RUN, 0 in BOOT, HOLD and HOLD_PEND.
REQ-028 epc SHALL change only on trap or misaligned redirect.
REQ-029 misalign SHALL be registered and cleared on the next edge unless a new misaligned redirect occurs.

Reset
REQ-030 While rst=0, independent of clk: pc=RESET_ADDR, epc=0, pend_addr=0, state=BOOT, pc_valid=0, misalign=0.
REQ-031 Reset asserted mid-stall or mid-pending SHALL discard the pending redirect.
REQ-032 Reset release SHALL take effect on the first falling clk edge after rst returns to 1.

Verification
REQ-033 Release reset, no events for 4 cycles -> pc 0, 0, 4, 8, 12; pc_valid 0, 0, 1, 1, 1.
REQ-034 RUN at pc=0x40, stall=1 with redir 0x200 for 2 cycles, then stall=0 -> pc holds 0x40 with pc_valid=0, then pc=0x200, then 0x204.
REQ-035 pc=0x80, trap_en=1 and redir_en=1 in the same cycle -> pc=0x100, epc=0x80; later mret_en=1 -> pc=0x80.
REQ-036 redir 0x302 at pc=0x10 -> misalign=1 for one cycle, pc=0x100, epc=0x10.
REQ-037 XLEN=32, pc=0xFFFF_FFFC, no events -> pc=0x0000_0000.
REQ-038 In HOLD_PEND with pend=0x500, drive rst=0 between edges -> pc=RESET_ADDR immediately; after release, 0x500 never appears on pc.
